// File: rtl/fastica_pkg.sv
// Shared constants for the normalisation blocks: default fixed-point format,
// row_sumsq FSM encoding and the saturation limit helper.
package fastica_pkg;
  localparam int W_DEF    = 26;
  localparam int FRAC_DEF = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Largest positive value of a w-bit signed word: 2^(w-1)-1.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/sq_sat_acc.sv
// Squares one signed fixed-point element and adds it to a running sum,
// clamping at the largest positive W-bit value.
module sq_sat_acc
  import fastica_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] acc_in,
  output logic [W-1:0] acc_out
);
  localparam logic signed [2*W-1:0] SAT = (2*W)'(sat_max(W));

  logic signed [2*W-1:0] dx, prod, sq, sum;

  // The square is kept at full width so an oversized element saturates
  // instead of wrapping into a small value.
  always_comb begin
    dx      = {{W{data[W-1]}}, data};
    prod    = dx * dx;
    sq      = prod >>> FRAC;
    sum     = sq + $signed({{W{1'b0}}, acc_in});
    acc_out = (sum > SAT) ? SAT[W-1:0] : sum[W-1:0];
  end
endmodule

// File: rtl/row_sumsq.sv
// Per-row sum of squares of a streamed 4x4 matrix; one shared squaring
// datapath, with the row picked by the upper counter bits.
module row_sumsq
  import fastica_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk_norm,
  input  logic         rst_norm_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] sum1,
  output logic [W-1:0] sum2,
  output logic [W-1:0] sum3,
  output logic [W-1:0] sum4,
  output logic         sums_valid,
  output logic         busy
);
  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] acc_q [4];
  logic [W-1:0] acc_d [4];
  logic [W-1:0] sum_q [4];
  logic [W-1:0] sum_d [4];
  logic [W-1:0] acc_new;
  logic         accept;

  assign in_ready   = (state_q == ST_ACCUM);
  assign accept     = in_ready & in_valid;
  assign sums_valid = (state_q == ST_DONE);
  assign busy       = (state_q == ST_ACCUM) | (state_q == ST_DONE);
  assign sum1       = sum_q[0];
  assign sum2       = sum_q[1];
  assign sum3       = sum_q[2];
  assign sum4       = sum_q[3];

  sq_sat_acc #(.W(W), .FRAC(FRAC)) u_sq (
    .data   (in_data),
    .acc_in (acc_q[cnt_q[3:2]]),
    .acc_out(acc_new)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: if (start) begin
        cnt_d   = '0;
        for (int r = 0; r < 4; r++) acc_d[r] = '0;
        state_d = ST_ACCUM;
      end
      ST_ACCUM: if (accept) begin
        acc_d[cnt_q[3:2]] = acc_new;
        cnt_d             = cnt_q + 4'd1;
        // Capture the sums on the final edge so they are stable during the
        // sums_valid cycle.
        if (cnt_q == 4'd15) begin
          state_d = ST_DONE;
          sum_d   = acc_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_norm or negedge rst_norm_n) begin
    if (!rst_norm_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int r = 0; r < 4; r++) begin
        acc_q[r] <= '0;
        sum_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
    end
  end
endmodule

// File: doc/row_sumsq.md
ROW_SUMSQ -- requirements
Module: row_sumsq

Interface
REQ-001 The block SHALL have parameter W, default 26, meaning the signed fixed-point data width.
REQ-002 The block SHALL have parameter FRAC, default 20, meaning the fractional bits of the data format.
REQ-003 The block SHALL have port clk_norm  input  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_norm_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start  input  1  begins one 4x4 matrix pass when sampled high in IDLE.
REQ-006 The block SHALL have port in_valid  input  1  in_data carries a valid element.
REQ-007 The block SHALL have port in_ready  output  1  block can accept an element this cycle.
REQ-008 The block SHALL have port in_data  input  W  signed matrix element, row-major order (i11..i14, i21..i44).
REQ-009 The block SHALL have ports sum1, sum2, sum3, sum4  output  W each  unsigned-valued row sums of squares, same fixed-point format.
REQ-010 The block SHALL have port sums_valid  output  1  one-cycle pulse when sum1..sum4 are updated.
REQ-011 The block SHALL have port busy  output  1  high in ACCUM and DONE.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-013 In IDLE with start=1, the FSM SHALL clear the element counter and all four accumulators, and SHALL move to ACCUM next cycle.
REQ-014 start SHALL be ignored in ACCUM and DONE.
REQ-015 in_ready SHALL be 1 only in ACCUM; an element SHALL be accepted on each cycle where in_valid and in_ready are both 1.
REQ-016 On each accepted element, the square SHALL be computed as the full 2W-bit signed product of in_data with itself, arithmetic-shifted right by FRAC and truncated.
REQ-017 Each accepted square SHALL be added to the accumulator of row counter[3:2].
REQ-018 Accumulation SHALL saturate at 2^(W-1)-1; a saturated accumulator SHALL stay saturated until cleared.
REQ-019 The 4-bit element counter SHALL increment per accepted element; on acceptance at count 15 the FSM SHALL move to DONE.
REQ-020 Cycles with in_valid=0 in ACCUM SHALL hold all state (no timeout).
REQ-021 In DONE, sum1..sum4 SHALL be loaded from the accumulators and sums_valid=1 for exactly that cycle, and the FSM SHALL return to IDLE next.
REQ-022 Latency SHALL be exactly one cycle from the 16th acceptance edge to the sums_valid cycle.
REQ-023 sum1..sum4 SHALL hold their values until the next DONE; a new pass SHALL NOT disturb them.
REQ-024 sum1..sum4 SHALL always be non-negative (bit W-1 = 0).

Reset
REQ-025 rst_norm_n low SHALL immediately force the FSM to IDLE and clear the counter, accumulators and sum1..sum4; in_ready, sums_valid and busy SHALL be 0.
REQ-026 Reset mid-pass SHALL abandon the pass with no sums_valid pulse; a following start SHALL begin a fresh pass.

Structure
REQ-027 The state encoding, the default W/FRAC and the saturation constant SHALL be in a shared package fastica_pkg.
REQ-028 The square-and-saturating-add datapath SHALL be one sub-module, sq_sat_acc, instantiated once and shared across rows via counter select.

Verification
REQ-029 Start followed by 16 back-to-back elements of 26'h0100000 (1.0) SHALL give sum1..sum4 = 26'h0400000 (4.0), sums_valid one cycle after the 16th, and busy low on the following cycle.
REQ-030 Row 1 = {-0.5, 0, 0, 0} (26'h3F80000) with all other elements 0 SHALL give sum1 = 26'h0040000 (0.25) and sum2..sum4 = 0.
REQ-031 Row 3 = {5.0, 5.0, 0, 0} (26'h0500000) SHALL give sum3 = 26'h1FFFFFF (saturated), with the other rows unaffected.
REQ-032 in_valid toggled with random gaps across 16 elements SHALL give sums identical to the back-to-back case, and in_ready SHALL be low in IDLE and DONE.
REQ-033 rst_norm_n pulsed after 9 elements SHALL give no sums_valid and zeroed outputs; a following full pass of 1.0 values SHALL give 26'h0400000 per row.
REQ-034 start asserted during ACCUM SHALL have no effect on counter, accumulators or timing.
